// File: rtl/gb_cpu_pkg.sv
// gb_cpu_pkg: definitions shared by the Game Boy CPU datapath blocks.
// - ALU opcodes (ADD/ADC/SUB/SBC) and flag bit positions inside F[7:4].
// - 16-bit sequencer op encodings and the sequencer state encoding.
// - Helpers that build the byte-pass ALU drive and the final 16-bit flags.
package gb_cpu_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_ADC = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_SBC = 5'b00011;

  // Flag positions within the 4-bit {Z,N,H,C} nibble.
  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_H = 1;
  localparam int F_C = 0;

  typedef enum logic [1:0] {
    ADD16 = 2'd0,
    ADDSP = 2'd1,
    INC16 = 2'd2,
    DEC16 = 2'd3
  } op16_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
  } alu_drive_t;

  // Low-byte pass: plain ADD (SUB for DEC16), no carry in.
  function automatic alu_drive_t lo_pass(input op16_e op, input logic [15:0] opa,
                                         input logic [15:0] opb);
    alu_drive_t d;
    d.a  = opa[7:0];
    d.b  = 8'h00;
    d.op = ALU_ADD;
    case (op)
      ADD16, ADDSP: d.b = opb[7:0];
      INC16:        d.b = 8'h01;
      DEC16: begin
        d.b  = 8'h01;
        d.op = ALU_SUB;
      end
      default:      d.b = 8'h00;
    endcase
    return d;
  endfunction

  // High-byte pass: carry/borrow chained from the low pass; ADDSP sign-extends e8.
  function automatic alu_drive_t hi_pass(input op16_e op, input logic [15:0] opa,
                                         input logic [15:0] opb);
    alu_drive_t d;
    d.a  = opa[15:8];
    d.b  = 8'h00;
    d.op = ALU_ADC;
    case (op)
      ADD16:   d.b = opb[15:8];
      ADDSP:   d.b = {8{opb[7]}};
      INC16:   d.b = 8'h00;
      DEC16:   d.op = ALU_SBC;
      default: d.b = 8'h00;
    endcase
    return d;
  endfunction

  // Flag nibble carrying only a carry/borrow bit.
  function automatic logic [3:0] carry_only(input logic c);
    logic [3:0] f;
    f      = 4'h0;
    f[F_C] = c;
    return f;
  endfunction

  // Flags reported at the end of a 16-bit op.
  function automatic logic [3:0] final_flags(input op16_e op, input logic [3:0] latched,
                                             input logic [3:0] hi_flags, input logic half_lo,
                                             input logic carry_lo);
    logic [3:0] f;
    f = latched;
    case (op)
      ADD16: begin
        f[F_N] = 1'b0;
        f[F_H] = hi_flags[F_H];
        f[F_C] = hi_flags[F_C];
      end
      ADDSP: begin
        f[F_Z] = 1'b0;
        f[F_N] = 1'b0;
        f[F_H] = half_lo;
        f[F_C] = carry_lo;
      end
      default: f = latched;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// alu16_seq: 16-bit arithmetic sequencer in front of the 8-bit Game Boy ALU.
// Runs ADD HL,rr / ADD SP,e8 / INC rr / DEC rr as a low-byte then high-byte
// pass through the ALU, chaining carry/borrow, and latches result and flags.
// Ports:
//   clk, rst (async, active-high)
//   start, op[1:0], opa[15:0], opb[15:0], flags_in[3:0]  - request, taken when ready=1
//   ready, done (1-cycle pulse), result[15:0], flags_out[3:0]
//   alu_own, alu_a, alu_b, alu_op, alu_flags_in          - drive to the parent's ALU
//   alu_result, alu_flags_out                             - ALU response
// Parameter BACK_TO_BACK: a start seen in DONE is accepted directly (DONE->LO).
// Optional macro ALU16_SEQ_FAST_INCDEC_EN: INC16/DEC16 bypass the ALU and
// complete one cycle after accept, leaving alu_own low.
module alu16_seq
  import gb_cpu_pkg::*;
#(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  flags_in,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output logic        alu_own,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flags_in,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags_out
);

  seq_state_e state_r;
  op16_e      op_r;
  logic [15:0] opa_r, opb_r, result_r;
  logic [3:0]  flags_r, flags_out_r, alu_fin_r;
  logic [7:0]  res_lo_r, alu_a_r, alu_b_r;
  logic [4:0]  alu_op_r;
  logic        carry_r, half_lo_r, ready_r, done_r, alu_own_r;

  op16_e       op_in_s;
  logic        accept_s, fast_s;
  logic [15:0] fast_res_s;
  alu_drive_t  lo_drv_s, hi_drv_s;

  // Accept decode and next ALU drive values for the upcoming pass.
  always_comb begin
    op_in_s  = op16_e'(op);
    accept_s = start && ((state_r == IDLE) || ((state_r == DONE) && (BACK_TO_BACK == 1'b1)));
    lo_drv_s = lo_pass(op_in_s, opa, opb);
    hi_drv_s = hi_pass(op_r, opa_r, opb_r);
`ifdef ALU16_SEQ_FAST_INCDEC_EN
    fast_s     = (op_in_s == INC16) || (op_in_s == DEC16);
    fast_res_s = (op_in_s == INC16) ? (opa + 16'd1) : (opa - 16'd1);
`else
    fast_s     = 1'b0;
    fast_res_s = 16'h0000;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= ADD16;
      opa_r       <= 16'h0000;
      opb_r       <= 16'h0000;
      flags_r     <= 4'h0;
      res_lo_r    <= 8'h00;
      carry_r     <= 1'b0;
      half_lo_r   <= 1'b0;
      result_r    <= 16'h0000;
      flags_out_r <= 4'h0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      alu_own_r   <= 1'b0;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      alu_op_r    <= ALU_ADD;
      alu_fin_r   <= 4'h0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        op_r    <= op_in_s;
        opa_r   <= opa;
        opb_r   <= opb;
        flags_r <= flags_in;
        if (fast_s) begin
          state_r     <= DONE;
          result_r    <= fast_res_s;
          flags_out_r <= flags_in;
          done_r      <= 1'b1;
          ready_r     <= 1'b1;
          alu_own_r   <= 1'b0;
        end else begin
          // Operands come straight from the ports: the latches above land this same edge.
          state_r   <= LO;
          ready_r   <= 1'b0;
          alu_own_r <= 1'b1;
          alu_a_r   <= lo_drv_s.a;
          alu_b_r   <= lo_drv_s.b;
          alu_op_r  <= lo_drv_s.op;
          alu_fin_r <= 4'h0;
        end
      end else begin
        case (state_r)
          LO: begin
            res_lo_r  <= alu_result;
            carry_r   <= alu_flags_out[F_C];
            half_lo_r <= alu_flags_out[F_H];
            alu_a_r   <= hi_drv_s.a;
            alu_b_r   <= hi_drv_s.b;
            alu_op_r  <= hi_drv_s.op;
            alu_fin_r <= carry_only(alu_flags_out[F_C]);
            state_r   <= HI;
          end
          HI: begin
            result_r    <= {alu_result, res_lo_r};
            flags_out_r <= final_flags(op_r, flags_r, alu_flags_out, half_lo_r, carry_r);
            done_r      <= 1'b1;
            ready_r     <= 1'b1;
            alu_own_r   <= 1'b0;
            alu_a_r     <= 8'h00;
            alu_b_r     <= 8'h00;
            alu_op_r    <= ALU_ADD;
            alu_fin_r   <= 4'h0;
            state_r     <= DONE;
          end
          DONE: begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
          IDLE: begin
            state_r <= IDLE;
          end
          default: begin
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            alu_own_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready        = ready_r;
  assign done         = done_r;
  assign result       = result_r;
  assign flags_out    = flags_out_r;
  assign alu_own      = alu_own_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign alu_flags_in = alu_fin_r;

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed + random checks of alu16_seq against a plain 16-bit
// arithmetic reference, with a behavioural Game Boy 8-bit ALU attached.
module tb_alu16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] opa = 16'h0000, opb = 16'h0000;
  logic [3:0]  flags_in = 4'h0;
  logic        ready, done, alu_own;
  logic [15:0] result;
  logic [3:0]  flags_out, alu_flags_in, alu_flags_out;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;

  int n_vec = 0;
  int n_err = 0;

  alu16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flags_in(flags_in), .ready(ready), .done(done), .result(result),
    .flags_out(flags_out), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_flags_in(alu_flags_in), .alu_result(alu_result),
    .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: flags {Z,N,H,C}; C/H are carries for add, borrows for sub.
  logic [8:0] alu_t;
  logic [4:0] alu_hn;
  always_comb begin
    alu_t  = 9'h000;
    alu_hn = 5'h00;
    alu_result    = 8'h00;
    alu_flags_out = 4'h0;
    case (alu_op)
      5'b00000, 5'b00001: begin
        alu_t  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, (alu_op[0] & alu_flags_in[0])};
        alu_hn = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, (alu_op[0] & alu_flags_in[0])};
        alu_result    = alu_t[7:0];
        alu_flags_out = {(alu_t[7:0] == 8'h00), 1'b0, alu_hn[4], alu_t[8]};
      end
      5'b00010, 5'b00011: begin
        alu_t  = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, (alu_op[0] & alu_flags_in[0])};
        alu_hn = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, (alu_op[0] & alu_flags_in[0])};
        alu_result    = alu_t[7:0];
        alu_flags_out = {(alu_t[7:0] == 8'h00), 1'b1, alu_hn[4], alu_t[8]};
      end
      default: alu_result = 8'h00;
    endcase
  end

  // Reference: {result, flags} from the instruction definitions, using 32-bit integer math.
  function automatic logic [19:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] f);
    int unsigned s, e;
    logic [15:0] r;
    logic [3:0]  fl;
    e  = 32'(b[7:0]);
    fl = f;
    r  = 16'h0000;
    case (o)
      2'd0: begin
        s  = 32'(a) + 32'(b);
        r  = 16'(s);
        fl = {f[3], 1'b0, ((32'(a) % 4096) + (32'(b) % 4096)) > 32'd4095, s > 32'd65535};
      end
      2'd1: begin
        r  = 16'((32'(a) + ((e >= 32'd128) ? (e + 32'd65280) : e)) % 65536);
        fl = {2'b00, ((32'(a) % 16) + (e % 16)) > 32'd15, ((32'(a) % 256) + e) > 32'd255};
      end
      2'd2: r = 16'((32'(a) + 32'd1) % 65536);
      default: r = 16'((32'(a) + 32'd65535) % 65536);
    endcase
    return {r, fl};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; pulse_cyc>0 raises start for one cycle while busy (must be ignored).
  task automatic run(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] f, input int pulse_cyc);
    logic [19:0] exp;
    int cyc, exp_lat;
    bit own_seen, fast;
    exp = ref_model(o, a, b, f);
`ifdef ALU16_SEQ_FAST_INCDEC_EN
    fast = (o >= 2'd2);
`else
    fast = 1'b0;
`endif
    exp_lat = fast ? 1 : 3;
    @(negedge clk);
    check("ready_before", 32'(ready), 32'd1);
    op = o; opa = a; opb = b; flags_in = f; start = 1'b1;
    cyc = 0; own_seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      own_seen |= alu_own;
      start = (cyc == pulse_cyc) ? 1'b1 : 1'b0;
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); flags_in = 4'($urandom);
    end while (!done && cyc < 8);
    start = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", 32'(result), 32'(exp[19:4]));
    check("flags", 32'(flags_out), 32'(exp[3:0]));
    check("alu_own_seen", 32'(own_seen), 32'(!fast));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(exp[19:4]));
  endtask

  logic [19:0] e1, e2;
  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_own", 32'(alu_own), 32'd0);
    check("rst_alu_drive", 32'({alu_a, alu_b, alu_op, alu_flags_in}), 32'd0);
    rst = 1'b0;

    // Directed cases, including the wrap boundaries.
    run(2'd0, 16'h0FFF, 16'h0001, 4'b1000, 0);
    check("add16_h_flags", 32'(flags_out), 32'(4'b1010));
    run(2'd0, 16'hFFFF, 16'h0001, 4'b0000, 0);
    check("add16_wrap", 32'(result), 32'h0000);
    run(2'd1, 16'h00FF, 16'h0001, 4'b1111, 0);
    check("addsp_flags", 32'(flags_out), 32'(4'b0011));
    run(2'd1, 16'h0000, 16'h00FF, 4'b1111, 0);
    check("addsp_neg", 32'(result), 32'hFFFF);
    run(2'd3, 16'h0000, 16'h0000, 4'b1010, 0);
    check("dec16_wrap", 32'(result), 32'hFFFF);
    run(2'd2, 16'hFFFF, 16'h1234, 4'b0101, 0);
    check("inc16_wrap", 32'(result), 32'h0000);
    run(2'd3, 16'h1200, 16'h0000, 4'b0011, 0);

    // Start pulsed during LO, then during HI: ignored.
    run(2'd0, 16'h1234, 16'h4321, 4'b0000, 1);
    run(2'd1, 16'hFFF8, 16'h0088, 4'b1000, 2);

    // Back-to-back: start held high across DONE.
    e1 = ref_model(2'd0, 16'h8421, 16'h7BDF, 4'b1000);
    e2 = ref_model(2'd1, 16'h8000, 16'h0080, 4'b0000);
    @(negedge clk);
    op = 2'd0; opa = 16'h8421; opb = 16'h7BDF; flags_in = 4'b1000; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op = 2'd1; opa = 16'h8000; opb = 16'h0080; flags_in = 4'b0000;
      end
      if (c == 3) begin
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_res1", 32'({result, flags_out}), 32'(e1));
      end
      if (c == 4) start = 1'b0;
      if (c == 4 || c == 5) check("b2b_gap", 32'(done), 32'd0);
      if (c == 6) begin
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_res2", 32'({result, flags_out}), 32'(e2));
      end
    end
    @(negedge clk);

    // Reset during HI aborts the op.
    op = 2'd0; opa = 16'h00F0; opb = 16'h0F10; flags_in = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_own", 32'(alu_own), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(2'd0, 16'h00F0, 16'h0F10, 4'b0000, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 4'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
